// File: rtl/boron_dec_round_ctrl_if.sv
// Handshake, key-store and round-datapath signals of the Boron decryption round sequencer.
// The slave modport is the sequencer's view; the master modport is its environment's view.
interface boron_dec_round_ctrl_if #(
    parameter int IDX_W = 5
);
    logic             Dec_In_valid;
    logic             Dec_In_ready;
    logic [63:0]      Dec_In_data;
    logic             Dec_Out_valid;
    logic             Dec_Out_ready;
    logic [63:0]      Dec_Out_data;
    logic [IDX_W-1:0] Rk_idx;
    logic [63:0]      Rk_data;
    logic [63:0]      Round_in;
    logic [63:0]      Round_out;
    logic             Busy;

    modport slave (
        input  Dec_In_valid, Dec_In_data, Dec_Out_ready, Rk_data, Round_out,
        output Dec_In_ready, Dec_Out_valid, Dec_Out_data, Rk_idx, Round_in, Busy
    );

    modport master (
        output Dec_In_valid, Dec_In_data, Dec_Out_ready, Rk_data, Round_out,
        input  Dec_In_ready, Dec_Out_valid, Dec_Out_data, Rk_idx, Round_in, Busy
    );
endinterface

// File: rtl/boron_dec_round_ctrl.sv
// Iterative Boron decryption sequencer: whiten with key ROUNDS, then ROUNDS rounds with keys ROUNDS-1..0.
// Latency ROUNDS+1 cycles to Dec_Out_valid; one block in flight; optional abort under BORON_DEC_ABORT_EN.
module boron_dec_round_ctrl #(
    parameter int ROUNDS = 25,
    parameter int IDX_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef BORON_DEC_ABORT_EN
    input  logic                      Dec_Abort,
`endif
    boron_dec_round_ctrl_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WHITEN,
        S_ROUND,
        S_OUT
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS);
    localparam logic [IDX_W-1:0] CNT_INIT = IDX_W'(ROUNDS - 1);

    state_t           state_q, state_d;
    logic [63:0]      blk_q, blk_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] rk_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            blk_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        cnt_d   = cnt_q;
        rk_idx  = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.Dec_In_valid) begin
                    blk_d   = bus.Dec_In_data;
                    cnt_d   = CNT_INIT;
                    state_d = S_WHITEN;
                end
            end
            S_WHITEN: begin
                rk_idx  = LAST_IDX;
                blk_d   = blk_q ^ bus.Rk_data;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                rk_idx = cnt_q;
                blk_d  = bus.Round_out;
                // Counter parks at zero on the final round rather than wrapping.
                if (cnt_q == '0) begin
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q - IDX_W'(1);
                end
            end
            S_OUT: begin
                if (bus.Dec_Out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef BORON_DEC_ABORT_EN
        // Abort wins over any transition, including the output handshake.
        if (Dec_Abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            blk_d   = '0;
            cnt_d   = '0;
        end
`endif
    end

    assign bus.Dec_In_ready  = (state_q == S_IDLE);
    assign bus.Dec_Out_valid = (state_q == S_OUT);
    assign bus.Busy          = (state_q != S_IDLE);
    assign bus.Dec_Out_data  = blk_q;
    assign bus.Round_in      = blk_q;
    assign bus.Rk_idx        = rk_idx;

endmodule

// File: doc/boron_dec_round_ctrl.md
# boron_dec_round_ctrl

Iterative round sequencer for the Boron decryption datapath. It accepts one 64-bit ciphertext over a valid/ready handshake and applies pre-whitening with the last round key. It then steps an external combinational decryption round (inverse block shuffle plus its sibling stages) `ROUNDS` times, addressing the round-key store in descending order. The plaintext is presented on a valid/ready output. It sits between the decryption input FIFO and the plaintext sink, and owns the round-key store's read address.

## Interface
- `ROUNDS`, default 25: number of decryption rounds; round keys are indexed 0..`ROUNDS`.
- `IDX_W`, default 5: width of the round-key index; must satisfy 2^`IDX_W` > `ROUNDS`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `Dec_In_valid`  in  1  ciphertext valid.
- `Dec_In_ready`  out  1  ready to accept ciphertext.
- `Dec_In_data`  in  64  ciphertext.
- `Dec_Out_valid`  out  1  plaintext valid.
- `Dec_Out_ready`  in  1  sink ready.
- `Dec_Out_data`  out  64  plaintext, driven from the state register.
- `Rk_idx`  out  `IDX_W`  round-key store read address.
- `Rk_data`  in  64  round key for `Rk_idx`; combinational, valid in the same cycle.
- `Round_in`  out  64  state fed to the external round datapath (= state register).
- `Round_out`  in  64  combinational round result for `Round_in`/`Rk_data`.
- `Busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WHITEN, ROUND, OUT.
- IDLE:
  - `Dec_In_ready` = 1.
  - On `Dec_In_valid` & `Dec_In_ready`: state reg <= `Dec_In_data`, round counter <= `ROUNDS`-1, go to WHITEN.
- WHITEN:
  - `Rk_idx` = `ROUNDS`.
  - State reg <= state reg ^ `Rk_data`; go to ROUND.
- ROUND:
  - `Rk_idx` = counter; state reg <= `Round_out`.
  - If counter == 0, go to OUT; else counter decrements by 1.
- OUT:
  - `Dec_Out_valid` = 1; `Dec_Out_data` holds stable.
  - On `Dec_Out_ready`: go to IDLE.
- `Rk_idx` = 0 in IDLE and OUT.
- The counter never wraps; it decrements only in ROUND, and only while it is nonzero.
- Only one block is in flight. `Dec_In_ready` is low in WHITEN, ROUND and OUT, so input presented during those states is held off, not dropped.
- No same-cycle turnaround: the OUT-to-IDLE transition spends one IDLE cycle before the next accept.

## Timing
- Reset values (asynchronous): state = IDLE, state reg = 0, counter = 0, `Dec_In_ready` = 1, `Dec_Out_valid` = 0, `Busy` = 0, `Rk_idx` = 0, `Dec_Out_data` = 0.
- Latency: for an accept at edge E0, WHITEN occupies cycle E0..E1 and ROUND occupies E1..E(`ROUNDS`+1). `Dec_Out_valid` rises after edge E(`ROUNDS`+1), i.e. 26 cycles at the default.
- Throughput with `Dec_Out_ready` tied high: one block per `ROUNDS`+3 cycles (28 at the default).
- Backpressure: OUT is held indefinitely; `Dec_Out_data` and `Dec_Out_valid` stay constant until the handshake.
- Reset mid-operation: the block returns to IDLE immediately. The partial block is discarded and no `Dec_Out_valid` pulse is produced.
- `Dec_In_valid` is ignored while `Busy` is high; there is no combinational path from `Dec_In_valid` to `Dec_In_ready`.

## Configuration
- Macro: `BORON_DEC_ABORT_EN`.
- Defined:
  - Adds input port `Dec_Abort` (1 bit).
  - When `Dec_Abort` = 1 at a rising edge in WHITEN, ROUND or OUT: state -> IDLE, state reg <= 0, counter <= 0. `Dec_Out_valid` drops in the next cycle.
  - Abort takes priority over an `Dec_Out_ready` handshake in the same cycle; that block is not delivered.
  - `Dec_Abort` in IDLE has no effect, and an accept in the same cycle still occurs.
- Undefined: the port does not exist and behaviour is exactly as above.

## Test plan
- Bench stub: `Round_out` = `Round_in` ^ `Rk_data`, and the key store returns `Rk_data` = {59'b0, `Rk_idx`}.
- Nominal: ct 0x0123456789ABCDEF with `Dec_Out_ready` = 1 -> `Dec_Out_data` = 0x0123456789ABCDEE (XOR of keys 0..25 = 1).
  - Check `Dec_Out_valid` rises 26 cycles after the accept.
  - Check `Rk_idx` sequence 25, 24, ..., 0.
- Backpressure: hold `Dec_Out_ready` = 0 for 10 cycles in OUT -> `Dec_Out_valid` and `Dec_Out_data` stay constant, `Dec_In_ready` = 0 throughout, and exactly one handshake occurs on release.
- Back-to-back: `Dec_In_valid` held high with ct 0 then 0xFFFFFFFFFFFFFFFF -> outputs 0x0000000000000001 then 0xFFFFFFFFFFFFFFFE, second accept exactly 28 cycles after the first.
- Reset mid-block: assert `rst` during ROUND with counter = 12 -> outputs immediately take reset values, no `Dec_Out_valid`, and the next block decrypts correctly.
- Abort (`BORON_DEC_ABORT_EN` defined): pulse `Dec_Abort` in ROUND with counter = 5 -> IDLE next cycle, `Busy` = 0, no output.
  - Pulse `Dec_Abort` in OUT together with `Dec_Out_ready` = 1 -> no output handshake counted.
